// File: rtl/alu_exec_stage_if.sv
// Handshake bundle for the execute stage: upstream op channel, downstream
// result channel, flush and the overflow event counter.
interface alu_exec_stage_if #(
   parameter int CNT_W = 8
);
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       in_op;
   logic [15:0]      in_a;
   logic [15:0]      in_b;
   logic             out_valid;
   logic             out_ready;
   logic [15:0]      out_res;
   logic [3:0]       out_flags;
   logic [CNT_W-1:0] ovf_cnt;

   // Execute unit side
   modport slave (
      input  flush, in_valid, in_op, in_a, in_b, out_ready,
      output in_ready, out_valid, out_res, out_flags, ovf_cnt
   );

   // Pipeline driver / consumer side
   modport master (
      output flush, in_valid, in_op, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_res, out_flags, ovf_cnt
   );
endinterface

// File: rtl/alu_exec_stage.sv
// Two-stage 16-bit execute unit. Stage 1 latches opcode and operands; stage 2
// evaluates them on a four-slice carry-lookahead adder plus a shifter and
// registers result, {N,Z,C,V} flags and a saturating overflow count.
module alu_exec_stage #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   alu_exec_stage_if.slave   bus
);
   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SLL = 3'b101;
   localparam logic [2:0] OP_SRL = 3'b110;
   localparam logic [2:0] OP_SRA = 3'b111;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // Group generate/propagate of one 4-bit slice: {G, P}
   function automatic logic [1:0] gp4(input logic [3:0] a, input logic [3:0] b);
      logic [3:0] g;
      logic [3:0] p;
      g = a & b;
      p = a ^ b;
      return {g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]),
              &p};
   endfunction

   // Sum of one 4-bit slice with internal lookahead carries
   function automatic logic [3:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                       input logic cin);
      logic [3:0] g;
      logic [3:0] p;
      logic [3:0] c;
      g    = a & b;
      p    = a ^ b;
      c[0] = cin;
      c[1] = g[0] | (p[0] & cin);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
      return p ^ c;
   endfunction

   logic             v1_r;
   logic [2:0]       op1_r;
   logic [WIDTH-1:0] a1_r;
   logic [WIDTH-1:0] b1_r;

   logic             out_valid_r;
   logic [WIDTH-1:0] res_r;
   logic [3:0]       flags_r;
   logic [CNT_W-1:0] ovf_cnt_r;

   logic             adv2_s;
   logic             in_ready_s;
   logic             is_arith_s;
   logic [WIDTH-1:0] b_eff_s;
   logic [3:0]       g_s;
   logic [3:0]       p_s;
   logic [4:0]       sc_s;
   logic [WIDTH-1:0] sum_s;
   logic [3:0]       shamt_s;
   logic [WIDTH:0]   sll_s;
   logic [WIDTH:0]   srl_s;
   logic [WIDTH:0]   sra_s;
   logic [WIDTH-1:0] res_s;
   logic             c_s;
   logic             v_s;
   logic             ovf_inc_s;

   assign adv2_s     = v1_r & (~out_valid_r | bus.out_ready);
   assign in_ready_s = ~v1_r | adv2_s;

   // Adder operand conditioning and cross-slice carry lookahead
   always_comb begin
      is_arith_s = (op1_r == OP_ADD) || (op1_r == OP_SUB);
      b_eff_s    = (op1_r == OP_SUB) ? ~b1_r : b1_r;
      for (int i = 0; i < 4; i++) begin
         {g_s[i], p_s[i]} = gp4(a1_r[4*i +: 4], b_eff_s[4*i +: 4]);
      end
      sc_s[0] = (op1_r == OP_SUB);
      sc_s[1] = g_s[0] | (p_s[0] & sc_s[0]);
      sc_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & sc_s[0]);
      sc_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
              | (p_s[2] & p_s[1] & p_s[0] & sc_s[0]);
      sc_s[4] = g_s[3] | (p_s[3] & sc_s[3]);
      for (int i = 0; i < 4; i++) begin
         sum_s[4*i +: 4] = cla4(a1_r[4*i +: 4], b_eff_s[4*i +: 4], sc_s[i]);
      end
   end

   // Result and carry/overflow selection; shifts carry the last bit shifted out
   always_comb begin
      shamt_s = b1_r[3:0];
      sll_s   = {1'b0, a1_r} << shamt_s;
      srl_s   = {a1_r, 1'b0} >> shamt_s;
      sra_s   = $signed({a1_r, 1'b0}) >>> shamt_s;
      res_s   = sum_s;
      c_s     = 1'b0;
      v_s     = 1'b0;
      case (op1_r)
         OP_ADD, OP_SUB: begin
            res_s = sum_s;
            c_s   = sc_s[4];
            // carry into bit 15 recovered from the MSB sum bit
            v_s   = sc_s[4] ^ (sum_s[WIDTH-1] ^ a1_r[WIDTH-1] ^ b_eff_s[WIDTH-1]);
         end
         OP_AND:  res_s = a1_r & b1_r;
         OP_OR:   res_s = a1_r | b1_r;
         OP_XOR:  res_s = a1_r ^ b1_r;
         OP_SLL:  {c_s, res_s} = sll_s;
         OP_SRL:  {res_s, c_s} = srl_s;
         OP_SRA:  {res_s, c_s} = sra_s;
         default: begin
            res_s = sum_s;
            c_s   = 1'b0;
            v_s   = 1'b0;
         end
      endcase
      ovf_inc_s = adv2_s & ~bus.flush & is_arith_s & v_s & (ovf_cnt_r != CNT_MAX);
   end

   // Stage 1: operand latch, emptied by flush, refilled whenever it can drain
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_r  <= 1'b0;
         op1_r <= 3'b000;
         a1_r  <= {WIDTH{1'b0}};
         b1_r  <= {WIDTH{1'b0}};
      end else if (bus.flush) begin
         v1_r <= 1'b0;
      end else if (in_ready_s) begin
         v1_r <= bus.in_valid;
         if (bus.in_valid) begin
            op1_r <= bus.in_op;
            a1_r  <= bus.in_a;
            b1_r  <= bus.in_b;
         end
      end
   end

   // Stage 2: result/flags register and saturating overflow counter
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         res_r       <= {WIDTH{1'b0}};
         flags_r     <= 4'b0000;
         ovf_cnt_r   <= {CNT_W{1'b0}};
      end else if (bus.flush) begin
         out_valid_r <= 1'b0;
      end else if (adv2_s) begin
         out_valid_r <= 1'b1;
         res_r       <= res_s;
         flags_r     <= {res_s[WIDTH-1], (res_s == {WIDTH{1'b0}}), c_s, v_s};
         if (ovf_inc_s) begin
            ovf_cnt_r <= ovf_cnt_r + CNT_ONE;
         end
      end else if (bus.out_ready) begin
         out_valid_r <= 1'b0;
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = out_valid_r;
   assign bus.out_res   = res_r;
   assign bus.out_flags = flags_r;
   assign bus.ovf_cnt   = ovf_cnt_r;
endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: directed vector table, backpressure/flush/reset
// sequences and a randomized stream scored against a plain-arithmetic model.
module tb_alu_exec_stage;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   alu_exec_stage_if #(.CNT_W(8)) bus ();
   alu_exec_stage #(.WIDTH(16), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic [2:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] res;
      logic [3:0]  flags;
   } vec_t;

   vec_t        tbl [17];
   int          n_vec = 0;
   int          n_err = 0;
   logic [19:0] exp_q [$];
   int          ovf_m = 0;
   bit          sb_on = 1'b0;
   bit          last_acc;
   int          n_acc;
   int          pops;

   // Reference: {N,Z,C,V,res} from the op definitions
   function automatic logic [19:0] ref_alu(input logic [2:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
      logic [15:0] r;
      logic        c;
      logic        v;
      int          sh;
      int unsigned s;
      sh = int'(b[3:0]);
      c  = 1'b0;
      v  = 1'b0;
      r  = 16'h0000;
      case (op)
         3'd0: begin
            s = 32'(a) + 32'(b);
            r = s[15:0];
            c = s[16];
            v = (a[15] == b[15]) && (r[15] != a[15]);
         end
         3'd1: begin
            r = a - b;
            c = (a >= b);
            v = (a[15] != b[15]) && (r[15] != a[15]);
         end
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: r = a ^ b;
         3'd5: begin
            r = a << sh;
            c = (sh == 0) ? 1'b0 : a[16-sh];
         end
         3'd6: begin
            r = a >> sh;
            c = (sh == 0) ? 1'b0 : a[sh-1];
         end
         default: begin
            r = $signed(a) >>> sh;
            c = (sh == 0) ? 1'b0 : a[sh-1];
         end
      endcase
      return {r[15], (r == 16'h0000), c, v, r};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic set_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      bus.in_op = op;
      bus.in_a  = a;
      bus.in_b  = b;
   endtask

   task automatic rand_op();
      logic [15:0] corner [4];
      corner[0] = 16'h7FFF; corner[1] = 16'h8000; corner[2] = 16'hFFFF; corner[3] = 16'h0000;
      set_op(3'($urandom_range(0, 7)),
             ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 16'($urandom),
             ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 16'($urandom));
   endtask

   // One clock: record transfers into/out of the model, then advance to next negedge
   task automatic tick();
      logic [19:0] r;
      logic [19:0] e;
      #1;
      last_acc = 1'b0;
      if (sb_on) begin
         if (bus.in_valid && bus.in_ready) begin
            r = ref_alu(bus.in_op, bus.in_a, bus.in_b);
            exp_q.push_back(r);
            last_acc = 1'b1;
            n_acc++;
            if (bus.in_op <= 3'd1 && r[16] && ovf_m < 255) ovf_m++;
         end
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               chk("spurious output", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("stream result", {12'h000, bus.out_flags, bus.out_res}, {12'h000, e});
               pops++;
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain();
      int guard;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      guard = 0;
      while (exp_q.size() > 0 && guard < 40) begin
         tick();
         guard++;
      end
      chk("drain complete", 32'(exp_q.size()), 32'd0);
      chk("ovf_cnt after drain", 32'(bus.ovf_cnt), 32'(ovf_m));
   endtask

   initial begin
      int flushed_seen;
      tbl[0]  = '{3'd0, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001};
      tbl[1]  = '{3'd1, 16'h0005, 16'h0005, 16'h0000, 4'b0110};
      tbl[2]  = '{3'd1, 16'h0000, 16'h0001, 16'hFFFF, 4'b1000};
      tbl[3]  = '{3'd7, 16'h8001, 16'h0001, 16'hC000, 4'b1010};
      tbl[4]  = '{3'd5, 16'h8000, 16'h0000, 16'h8000, 4'b1000};
      tbl[5]  = '{3'd6, 16'h00F0, 16'h0004, 16'h000F, 4'b0000};
      tbl[6]  = '{3'd2, 16'hFFFF, 16'h0F0F, 16'h0F0F, 4'b0000};
      tbl[7]  = '{3'd3, 16'h0000, 16'h0000, 16'h0000, 4'b0100};
      tbl[8]  = '{3'd4, 16'hAAAA, 16'h5555, 16'hFFFF, 4'b1000};
      tbl[9]  = '{3'd0, 16'hFFFF, 16'h0001, 16'h0000, 4'b0110};
      tbl[10] = '{3'd1, 16'h8000, 16'h0001, 16'h7FFF, 4'b0011};
      tbl[11] = '{3'd5, 16'h0001, 16'h000F, 16'h8000, 4'b1000};
      tbl[12] = '{3'd6, 16'h8000, 16'h000F, 16'h0001, 4'b0000};
      tbl[13] = '{3'd7, 16'h8000, 16'h000F, 16'hFFFF, 4'b1000};
      tbl[14] = '{3'd5, 16'h00FF, 16'h0014, 16'h0FF0, 4'b0000};
      tbl[15] = '{3'd0, 16'h4000, 16'h4000, 16'h8000, 4'b1001};
      tbl[16] = '{3'd6, 16'h0003, 16'h0001, 16'h0001, 4'b0010};

      rst = 1'b1;
      bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      set_op(3'd0, 16'h0000, 16'h0000);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("reset out_valid", 32'(bus.out_valid), 32'd0);
      chk("reset out_res",   32'(bus.out_res),   32'd0);
      chk("reset out_flags", 32'(bus.out_flags), 32'd0);
      chk("reset ovf_cnt",   32'(bus.ovf_cnt),   32'd0);
      chk("reset in_ready",  32'(bus.in_ready),  32'd1);

      // Directed table: one op at a time, latency and flags checked exactly
      for (int i = 0; i < 17; i++) begin
         bus.out_ready = 1'b1;
         bus.in_valid  = 1'b1;
         set_op(tbl[i].op, tbl[i].a, tbl[i].b);
         @(posedge clk);
         @(negedge clk);
         bus.in_valid = 1'b0;
         chk("latency: not yet valid", 32'(bus.out_valid), 32'd0);
         @(posedge clk);
         @(negedge clk);
         if (tbl[i].op <= 3'd1 && tbl[i].flags[0]) ovf_m++;
         chk("table out_valid", 32'(bus.out_valid), 32'd1);
         chk("table out_res",   32'(bus.out_res),   32'(tbl[i].res));
         chk("table out_flags", 32'(bus.out_flags), 32'(tbl[i].flags));
         chk("table ovf_cnt",   32'(bus.ovf_cnt),   32'(ovf_m));
         @(posedge clk);
         @(negedge clk);
         chk("output drop", 32'(bus.out_valid), 32'd0);
      end

      // Backpressure: 4 back-to-back ops with out_ready low for 3 cycles
      sb_on = 1'b1; n_acc = 0; pops = 0;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      rand_op();
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("backpressure in_ready", 32'(bus.in_ready), (c < 2) ? 32'd1 : 32'd0);
         tick();
         if (last_acc) rand_op();
      end
      bus.out_ready = 1'b1;
      for (int g = 0; g < 20 && n_acc < 4; g++) begin
         tick();
         if (last_acc) rand_op();
         if (n_acc >= 4) bus.in_valid = 1'b0;
      end
      drain();
      chk("backpressure op count", 32'(pops), 32'd4);

      // Flush with both stages full and a new op offered
      sb_on = 1'b0;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      set_op(3'd0, 16'h4000, 16'h4000);
      @(posedge clk); @(negedge clk);
      @(posedge clk); @(negedge clk);
      if (ovf_m < 255) ovf_m++;
      chk("flush setup out_valid", 32'(bus.out_valid), 32'd1);
      chk("flush setup in_ready",  32'(bus.in_ready),  32'd0);
      bus.flush     = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      chk("flush out_valid", 32'(bus.out_valid), 32'd0);
      chk("flush in_ready",  32'(bus.in_ready),  32'd1);
      chk("flush ovf_cnt",   32'(bus.ovf_cnt),   32'(ovf_m));
      flushed_seen = 0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); @(negedge clk);
         if (bus.out_valid) flushed_seen++;
      end
      chk("flushed op reappeared", 32'(flushed_seen), 32'd0);

      // Randomized stream with random stalls
      sb_on = 1'b1; exp_q.delete();
      for (int c = 0; c < 400; c++) begin
         bus.in_valid  = ($urandom_range(0, 9) < 7);
         bus.out_ready = ($urandom_range(0, 9) < 7);
         rand_op();
         tick();
      end
      drain();

      // Saturation: 300 overflowing ADDs at full throughput
      n_acc = 0;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      set_op(3'd0, 16'h4000, 16'h4000);
      for (int c = 0; c < 300; c++) tick();
      chk("full throughput", 32'(n_acc), 32'd300);
      drain();
      chk("ovf_cnt saturated", 32'(bus.ovf_cnt), 32'hFF);

      // Reset mid-stream
      bus.in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         rand_op();
         tick();
      end
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("mid reset out_valid", 32'(bus.out_valid), 32'd0);
      chk("mid reset out_res",   32'(bus.out_res),   32'd0);
      chk("mid reset out_flags", 32'(bus.out_flags), 32'd0);
      chk("mid reset ovf_cnt",   32'(bus.ovf_cnt),   32'd0);
      chk("mid reset in_ready",  32'(bus.in_ready),  32'd1);
      rst = 1'b0;
      bus.in_valid = 1'b0;
      exp_q.delete();
      ovf_m = 0;
      bus.in_valid = 1'b1;
      set_op(3'd1, 16'h1234, 16'h0234);
      tick();
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
